// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the MAC timestep scheduler.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ACCUM = 2'd2,
        CLEAR = 2'd3
    } sched_state_t;

    localparam int DEF_ADDR_W = 12;
    localparam logic [DEF_ADDR_W-1:0] DEF_NULL_ADDR = 12'hFFF;

    // Width of a down-counter that must hold values up to max_val-1.
    function automatic int down_cnt_w(input int max_val);
        return (max_val > 2) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starts at the slot after the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;

    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Walk from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[rot_idx(ptr, k)]) begin
                grant                  = '0;
                grant[rot_idx(ptr, k)] = 1'b1;
                ptr_nxt                = rot_idx(ptr, k + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mac_timestep_scheduler.sv
// Timestep sequencer and spike arbiter in front of one neuron MAC.
// Optional MAC_SCHED_STATS_EN adds per-timestep spike/stall counters (stat_spikes, stat_stall).
//
// state | meaning
// IDLE  | waiting for start, no grants
// INIT  | mac_set held for INIT_CYCLES
// ACCUM | ACCUM_CYCLES of spike arbitration
// CLEAR | one cycle: mac_clear, ts_done, ts_index advance
module mac_timestep_scheduler
    import mac_sched_pkg::*;
#(
    parameter int                NUM_REQ      = 4,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                INIT_CYCLES  = 2,
    parameter int                ACCUM_CYCLES = 3,
    parameter int                TS_W         = 16,
    parameter logic [ADDR_W-1:0] NULL_ADDR    = DEF_NULL_ADDR
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      stop,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mac_set,
    output logic                      mac_clear,
    output logic [ADDR_W-1:0]         mac_src_addr,
    output logic                      mac_src_valid,
    output logic                      ts_done,
    output logic [TS_W-1:0]           ts_index,
    output logic                      busy
`ifdef MAC_SCHED_STATS_EN
    ,
    output logic [TS_W-1:0]           stat_spikes,
    output logic [TS_W-1:0]           stat_stall
`endif
);

    localparam int MAX_CYC = (INIT_CYCLES > ACCUM_CYCLES) ? INIT_CYCLES : ACCUM_CYCLES;
    localparam int CNT_W   = down_cnt_w(MAX_CYC);
    localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACCUM_LOAD = CNT_W'(ACCUM_CYCLES - 1);

    sched_state_t       state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               stop_q, stop_nxt;
    logic               cnt_tc;
    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] grant;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;

    assign cnt_tc = (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stop_nxt  = stop_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                    cnt_nxt   = INIT_LOAD;
                end
            end
            INIT: begin
                if (stop) stop_nxt = 1'b1;
                if (cnt_tc) begin
                    state_nxt = ACCUM;
                    cnt_nxt   = ACCUM_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACCUM: begin
                if (stop) stop_nxt = 1'b1;
                if (cnt_tc) begin
                    state_nxt = CLEAR;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CLEAR: begin
                // A stop arriving in the CLEAR cycle itself also ends the run here.
                if (stop_q || stop) begin
                    state_nxt = IDLE;
                    stop_nxt  = 1'b0;
                end else begin
                    state_nxt = ACCUM;
                    cnt_nxt   = ACCUM_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A requester whose address is on the MAC bus right now waits one cycle,
    // so equal back-to-back spikes are separated by NULL_ADDR.
    always_comb begin
        req_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_elig[i] = req_valid[i] && (state == ACCUM) &&
                          !(mac_src_valid && (req_addr[i*ADDR_W +: ADDR_W] == mac_src_addr));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req_elig),
        .advance (transfer),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            stop_q        <= 1'b0;
            ts_index      <= '0;
            mac_src_valid <= 1'b0;
            mac_src_addr  <= NULL_ADDR;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            stop_q        <= stop_nxt;
            mac_src_valid <= transfer;
            mac_src_addr  <= transfer ? sel_addr : NULL_ADDR;
            if (state == CLEAR) ts_index <= ts_index + 1'b1;
        end
    end

    assign mac_set   = (state == INIT);
    assign mac_clear = (state == CLEAR);
    assign ts_done   = (state == CLEAR);
    assign busy      = (state != IDLE);

`ifdef MAC_SCHED_STATS_EN
    logic [TS_W-1:0] spk_acc;
    logic [TS_W-1:0] stall_acc;
    logic            stall_c;

    assign stall_c = (|req_valid) && !transfer;

    // Counting window is the timestep proper: ACCUM cycles plus the CLEAR cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            spk_acc     <= '0;
            stall_acc   <= '0;
            stat_spikes <= '0;
            stat_stall  <= '0;
        end else if (state == CLEAR) begin
            stat_spikes <= spk_acc;
            stat_stall  <= stall_acc + TS_W'(stall_c);
            spk_acc     <= '0;
            stall_acc   <= '0;
        end else if (state == ACCUM) begin
            spk_acc   <= spk_acc + TS_W'(transfer);
            stall_acc <= stall_acc + TS_W'(stall_c);
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_mac_timestep_scheduler.sv
// Self-checking bench for mac_timestep_scheduler: vector table, directed corner cases, random vs. model.
module tb_mac_timestep_scheduler;

    localparam int NREQ    = 4;
    localparam int AW      = 12;
    localparam int INIT_C  = 2;
    localparam int ACCUM_C = 3;
    localparam logic [11:0] NULLA = 12'hFFF;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [11:0]     ra [4];
    logic [47:0]     req_addr;

    logic [3:0]      req_ready, req_ready_b;
    logic            mac_set, mac_set_b, mac_clear, mac_clear_b;
    logic [11:0]     mac_src_addr, mac_src_addr_b;
    logic            mac_src_valid, mac_src_valid_b, ts_done, ts_done_b, busy, busy_b;
    logic [15:0]     ts_index;
    logic [1:0]      ts_index_b;
`ifdef MAC_SCHED_STATS_EN
    logic [15:0]     stat_spikes, stat_stall;
    logic [1:0]      stat_spikes_b, stat_stall_b;
`endif

    assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

    always #5 CLK = ~CLK;

    mac_timestep_scheduler #(.TS_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mac_set(mac_set), .mac_clear(mac_clear), .mac_src_addr(mac_src_addr),
        .mac_src_valid(mac_src_valid), .ts_done(ts_done), .ts_index(ts_index),
        .busy(busy)
`ifdef MAC_SCHED_STATS_EN
        , .stat_spikes(stat_spikes), .stat_stall(stat_stall)
`endif
    );

    mac_timestep_scheduler #(.TS_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_b),
        .mac_set(mac_set_b), .mac_clear(mac_clear_b), .mac_src_addr(mac_src_addr_b),
        .mac_src_valid(mac_src_valid_b), .ts_done(ts_done_b), .ts_index(ts_index_b),
        .busy(busy_b)
`ifdef MAC_SCHED_STATS_EN
        , .stat_spikes(stat_spikes_b), .stat_stall(stat_stall_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic [3:0]  rv;
        logic        e_busy;
        logic        e_set;
        logic        e_clr;
        logic [3:0]  e_rdy;
        logic        e_sv;
        logic [11:0] e_sa;
        logic [15:0] e_ts;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [3:0] rv, input logic b, input logic s,
                                input logic c, input logic [3:0] r, input logic sv,
                                input logic [11:0] sa, input logic [15:0] ts);
        vec_t v;
        v.st = st; v.rv = rv; v.e_busy = b; v.e_set = s; v.e_clr = c;
        v.e_rdy = r; v.e_sv = sv; v.e_sa = sa; v.e_ts = ts;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    int         m_run, m_k, m_stop, m_ts, m_ptr, m_sv;
    logic [11:0] m_sa;
    logic [3:0] m_xfer;
    int         m_spk_acc, m_stall_acc, m_stat_spk, m_stat_stall;

    task automatic m_reset();
        m_run = 0; m_k = 0; m_stop = 0; m_ts = 0; m_ptr = 0; m_sv = 0; m_sa = NULLA;
        m_xfer = '0; m_spk_acc = 0; m_stall_acc = 0; m_stat_spk = 0; m_stat_stall = 0;
    endtask

    // 0 idle, 1 init, 2 accum, 3 clear, from elapsed cycles since start.
    function automatic int m_phase();
        int j;
        if (m_run == 0) return 0;
        if (m_k < INIT_C) return 1;
        j = (m_k - INIT_C) % (ACCUM_C + 1);
        return (j < ACCUM_C) ? 2 : 3;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int i;
        r = '0;
        if (m_phase() != 2) return r;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i] && !(m_sv != 0 && ra[i] == m_sa)) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic m_step();
        logic [3:0] g;
        int ph;
        g  = m_ready();
        ph = m_phase();
        m_xfer = g;
        if (RST) begin
            m_reset();
            m_xfer = g;
            return;
        end
        m_sv = 0;
        m_sa = NULLA;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                m_sv  = 1;
                m_sa  = ra[i];
                m_ptr = (i + 1) % NREQ;
            end
        end
        if (ph == 2) begin
            m_spk_acc   += (g != 0) ? 1 : 0;
            m_stall_acc += (req_valid != 0 && g == 0) ? 1 : 0;
        end else if (ph == 3) begin
            m_stat_spk   = m_spk_acc;
            m_stat_stall = m_stall_acc + ((req_valid != 0) ? 1 : 0);
            m_spk_acc    = 0;
            m_stall_acc  = 0;
        end
        if (m_run == 0) begin
            if (start) begin
                m_run = 1;
                m_k   = 0;
            end
        end else if (ph == 3) begin
            m_ts++;
            if (m_stop != 0 || stop) begin
                m_run  = 0;
                m_stop = 0;
            end else begin
                m_k++;
            end
        end else begin
            if (stop) m_stop = 1;
            m_k++;
        end
    endtask

    task automatic m_check();
        int ph;
        ph = m_phase();
        chk("rnd_busy", 32'(busy), (ph != 0) ? 32'd1 : 32'd0);
        chk("rnd_set", 32'(mac_set), (ph == 1) ? 32'd1 : 32'd0);
        chk("rnd_clear", 32'(mac_clear), (ph == 3) ? 32'd1 : 32'd0);
        chk("rnd_ts_done", 32'(ts_done), (ph == 3) ? 32'd1 : 32'd0);
        chk("rnd_ready", 32'(req_ready), 32'(m_ready()));
        chk("rnd_src_valid", 32'(mac_src_valid), 32'(m_sv));
        chk("rnd_src_addr", 32'(mac_src_addr), 32'(m_sa));
        chk("rnd_ts_index", 32'(ts_index), 32'(m_ts % 65536));
        chk("rnd_ts_index_w2", 32'(ts_index_b), 32'(m_ts % 4));
`ifdef MAC_SCHED_STATS_EN
        chk("rnd_stat_spikes", 32'(stat_spikes), 32'(m_stat_spk));
        chk("rnd_stat_stall", 32'(stat_stall), 32'(m_stat_stall));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl [12];
        int   nclr;
        int   seen3;

        for (int i = 0; i < NREQ; i++) ra[i] = 12'(i);

        // Reset + first two timesteps with all four requesters busy.
        tbl[0]  = mk(1, 4'hF, 0, 0, 0, 4'h0, 0, NULLA, 0);
        tbl[1]  = mk(0, 4'hF, 1, 1, 0, 4'h0, 0, NULLA, 0);
        tbl[2]  = mk(0, 4'hF, 1, 1, 0, 4'h0, 0, NULLA, 0);
        tbl[3]  = mk(0, 4'hF, 1, 0, 0, 4'h1, 0, NULLA, 0);
        tbl[4]  = mk(0, 4'hF, 1, 0, 0, 4'h2, 1, 12'd0, 0);
        tbl[5]  = mk(0, 4'hF, 1, 0, 0, 4'h4, 1, 12'd1, 0);
        tbl[6]  = mk(0, 4'hF, 1, 0, 1, 4'h0, 1, 12'd2, 0);
        tbl[7]  = mk(0, 4'hF, 1, 0, 0, 4'h8, 0, NULLA, 1);
        tbl[8]  = mk(0, 4'hF, 1, 0, 0, 4'h1, 1, 12'd3, 1);
        tbl[9]  = mk(0, 4'hF, 1, 0, 0, 4'h2, 1, 12'd0, 1);
        tbl[10] = mk(0, 4'hF, 1, 0, 1, 4'h0, 1, 12'd1, 1);
        tbl[11] = mk(0, 4'h0, 1, 0, 0, 4'h0, 0, NULLA, 2);

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int r = 0; r < 12; r++) begin
            start     = tbl[r].st;
            req_valid = tbl[r].rv;
            #4;
            chk("tbl_busy", 32'(busy), 32'(tbl[r].e_busy));
            chk("tbl_set", 32'(mac_set), 32'(tbl[r].e_set));
            chk("tbl_clear", 32'(mac_clear), 32'(tbl[r].e_clr));
            chk("tbl_ts_done", 32'(ts_done), 32'(tbl[r].e_clr));
            chk("tbl_ready", 32'(req_ready), 32'(tbl[r].e_rdy));
            chk("tbl_src_valid", 32'(mac_src_valid), 32'(tbl[r].e_sv));
            chk("tbl_src_addr", 32'(mac_src_addr), 32'(tbl[r].e_sa));
            chk("tbl_ts_index", 32'(ts_index), 32'(tbl[r].e_ts));
`ifdef MAC_SCHED_STATS_EN
            if (r == 7) begin
                chk("stat_spikes", 32'(stat_spikes), 32'd3);
                chk("stat_stall", 32'(stat_stall), 32'd1);
            end
`endif
            cyc();
        end
        start = 1'b0;

        // Same address twice from requester 0 must be split by a NULL cycle.
        RST = 1'b1; req_valid = '0; ra[0] = 12'd1;
        cyc();
        RST = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        req_valid = 4'b0001;
        #4; chk("dup_a1_ready", 32'(req_ready), 32'h1);
        cyc();
        #4; chk("dup_a2_addr", 32'(mac_src_addr), 32'd1);
        chk("dup_a2_ready", 32'(req_ready), 32'h0);
        cyc();
        #4; chk("dup_a3_addr", 32'(mac_src_addr), 32'(NULLA));
        chk("dup_a3_valid", 32'(mac_src_valid), 32'd0);
        chk("dup_a3_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #4; chk("dup_clr_addr", 32'(mac_src_addr), 32'd1);
        chk("dup_clr_clear", 32'(mac_clear), 32'd1);
        cyc();

        // stop on the first ACCUM cycle finishes the timestep, then IDLE; restart goes to INIT.
        RST = 1'b1;
        cyc();
        RST = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        stop = 1'b1;
        #4; chk("stop_a1_busy", 32'(busy), 32'd1);
        cyc();
        stop = 1'b0;
        cyc();
        cyc();
        #4; chk("stop_clear", 32'(mac_clear), 32'd1);
        cyc();
        #4; chk("stop_idle_busy", 32'(busy), 32'd0);
        nclr = 0;
        for (int c = 0; c < 8; c++) begin
            #4; if (mac_clear || busy) nclr++;
            cyc();
        end
        chk("stop_stays_idle", 32'(nclr), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        #4; chk("restart_set", 32'(mac_set), 32'd1);
        chk("restart_ts", 32'(ts_index), 32'd1);
        cyc();

        // Synchronous reset in ACCUM with requests pending.
        RST = 1'b1;
        cyc();
        RST = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        req_valid = 4'hF;
        #4; chk("rst_pre_ts", 32'(ts_index), 32'd1);
        chk("rst_pre_ready_nz", 32'(req_ready != 0), 32'd1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        #4; chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_clear", 32'(mac_clear), 32'd0);
        chk("rst_ts_done", 32'(ts_done), 32'd0);
        chk("rst_ts", 32'(ts_index), 32'd0);
        chk("rst_src_valid", 32'(mac_src_valid), 32'd0);
        chk("rst_src_addr", 32'(mac_src_addr), 32'(NULLA));
        cyc();
        req_valid = '0;

        // ts_index wrap on the 2-bit instance.
        RST = 1'b1;
        cyc();
        RST = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        nclr = 0; seen3 = 0;
        for (int c = 0; c < 60 && nclr < 4; c++) begin
            #4; if (mac_clear_b) nclr++;
            cyc();
            if (nclr == 3 && seen3 == 0) begin
                seen3 = 1;
                chk("wrap_ts3", 32'(ts_index_b), 32'd3);
            end
        end
        chk("wrap_clear_count", 32'(nclr), 32'd4);
        chk("wrap_ts0", 32'(ts_index_b), 32'd0);
        chk("wrap_ts_wide", 32'(ts_index), 32'd4);

        // Random traffic against the reference model.
        RST = 1'b1; stop = 1'b0; req_valid = '0;
        cyc();
        RST = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_xfer[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    ra[i]        = 12'($urandom_range(0, 5));
                end
            end
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            RST   = ($urandom_range(0, 499) == 0);
            #4;
            m_check();
            m_step();
            cyc();
        end
        RST = 1'b0; start = 1'b0; stop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
